// File: rtl/val2_pkg.sv
// rtl/val2_pkg.sv - Shared encodings, FSM states and widths for the val2 operand sequencer
package val2_pkg;

    localparam int AMT_W = 5;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/val2_step.sv
// rtl/val2_step.sv - Combinational one-step shifter (1 or 4 positions) for LSL/LSR/ASR/ROR
module val2_step
    import val2_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        op,
    input  logic              by4,
    output logic [DATA_W-1:0] q
);

    // Apply the selected operation by one or four bit positions
    always_comb begin
        q = data;
        if (by4) begin
            case (op)
                SH_LSL:  q = {data[DATA_W-5:0], 4'b0000};
                SH_LSR:  q = {4'b0000, data[DATA_W-1:4]};
                SH_ASR:  q = {{4{data[DATA_W-1]}}, data[DATA_W-1:4]};
                default: q = {data[3:0], data[DATA_W-1:4]};
            endcase
        end else begin
            case (op)
                SH_LSL:  q = {data[DATA_W-2:0], 1'b0};
                SH_LSR:  q = {1'b0, data[DATA_W-1:1]};
                SH_ASR:  q = {data[DATA_W-1], data[DATA_W-1:1]};
                default: q = {data[0], data[DATA_W-1:1]};
            endcase
        end
    end

endmodule

// File: rtl/val2_seq.sv
// rtl/val2_seq.sv - Multi-cycle Val2 sequencer; define VAL2_SEQ_RADIX4_EN for 4-position steps
module val2_seq
    import val2_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              imm,
    input  logic              ld_str,
    input  logic [11:0]       shift_operand,
    input  logic [DATA_W-1:0] val_rm,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              busy,
    output logic              stall
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] work;
    logic [DATA_W-1:0] step_out;
    logic [DATA_W-1:0] res_q;
    logic [1:0]        op;
    logic [AMT_W-1:0]  cnt;
    logic [AMT_W-1:0]  dec;
    logic              by4;

`ifdef VAL2_SEQ_RADIX4_EN
    assign by4 = (cnt >= AMT_W'(4));
`else
    assign by4 = 1'b0;
`endif

    assign dec    = by4 ? AMT_W'(4) : AMT_W'(1);
    assign result = res_q;

    val2_step #(.DATA_W(DATA_W)) u_step (
        .data (work),
        .op   (op),
        .by4  (by4),
        .q    (step_out)
    );

    // State register; reset drops any request in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = start;
                if (start) state_next = CALC;
            end
            CALC: begin
                busy       = 1'b1;
                stall      = 1'b1;
                state_next = (cnt == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                busy  = 1'b1;
                stall = 1'b1;
                if (cnt == dec) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iterative shifting and result latch on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work  <= '0;
            op    <= SH_LSL;
            cnt   <= '0;
            res_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (ld_str) begin
                            work <= {{(DATA_W-12){shift_operand[11]}}, shift_operand};
                            op   <= SH_LSL;
                            cnt  <= '0;
                        end else if (imm) begin
                            work <= {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
                            op   <= SH_ROR;
                            cnt  <= {shift_operand[11:8], 1'b0};
                        end else begin
                            work <= val_rm;
                            op   <= shift_operand[6:5];
                            cnt  <= shift_operand[11:7];
                        end
                    end
                end
                CALC: begin
                    if (cnt == '0) res_q <= work;
                end
                SHIFT: begin
                    work <= step_out;
                    cnt  <= cnt - dec;
                    if (cnt == dec) res_q <= step_out;
                end
                default: ;
            endcase
        end
    end

endmodule
